// File: rtl/alu_seq_if.sv
// Handshake and data bundle for alu_seq: operand side (in_*) and result side (out_*).
// The slave modport is the ALU, the master modport is the surrounding pipeline.
interface alu_seq_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] dtA_i;
    logic [DATA_W-1:0] dtB_i;
    logic [3:0]        alu_op_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] alu_dt_o;
    logic [TAG_W-1:0]  tag_o;
    logic              sign_o;
    logic              zero_o;
    logic              carry_o;
    logic              ovf_o;
    logic              busy_o;

    modport master (
        output in_valid_i, dtA_i, dtB_i, alu_op_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_dt_o, tag_o,
               sign_o, zero_o, carry_o, ovf_o, busy_o
    );

    modport slave (
        input  in_valid_i, dtA_i, dtB_i, alu_op_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_dt_o, tag_o,
               sign_o, zero_o, carry_o, ovf_o, busy_o
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, result flags and tag pass-through.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for opcode 1110.
module alu_seq #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input logic      clk_i,
    input logic      rst_n_i,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(DATA_W);
    localparam int CW = SW + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_ABS  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NEG  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_SLT  = 4'b1010,
        OP_SLTU = 4'b1011,
        OP_MIN  = 4'b1100,
        OP_MAX  = 4'b1101,
        OP_MUL  = 4'b1110,
        OP_PASS = 4'b1111
    } op_e;

    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SW-1:0]     shamt;
    logic [DATA_W:0]   add_w;
    logic [DATA_W-1:0] sub_w;
    logic [DATA_W-1:0] neg_b;
    logic              b_is_min;
    logic              slt_s;
    logic              slt_u;
    logic [DATA_W-1:0] res_c;
    logic              carry_c;
    logic              ovf_c;

    assign op       = op_e'(bus.alu_op_i);
    assign a        = bus.dtA_i;
    assign b        = bus.dtB_i;
    assign shamt    = b[SW-1:0];
    assign add_w    = {1'b0, a} + {1'b0, b};
    assign sub_w    = a - b;
    assign neg_b    = '0 - b;
    assign b_is_min = (b == {1'b1, {(DATA_W-1){1'b0}}});
    assign slt_s    = $signed(a) < $signed(b);
    assign slt_u    = a < b;

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op)
            OP_ADD: begin
                res_c   = add_w[DATA_W-1:0];
                carry_c = add_w[DATA_W];
                ovf_c   = (a[DATA_W-1] == b[DATA_W-1]) && (add_w[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                res_c   = sub_w;
                carry_c = slt_u;
                ovf_c   = (a[DATA_W-1] != b[DATA_W-1]) && (sub_w[DATA_W-1] != a[DATA_W-1]);
            end
            OP_ABS: begin
                res_c = b[DATA_W-1] ? neg_b : b;
                ovf_c = b_is_min;
            end
            OP_NEG: begin
                res_c = neg_b;
                ovf_c = b_is_min;
            end
            OP_SLL:  res_c = a << shamt;
            OP_SRL:  res_c = a >> shamt;
            OP_SRA:  res_c = $signed(a) >>> shamt;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_SLT:  res_c = {{(DATA_W-1){1'b0}}, slt_s};
            OP_SLTU: res_c = {{(DATA_W-1){1'b0}}, slt_u};
            OP_MIN:  res_c = slt_s ? a : b;
            OP_MAX:  res_c = slt_s ? b : a;
            OP_PASS: res_c = a;
            default: res_c = '0;
        endcase
    end

    logic free;
    logic drain;
    logic accept;
    logic idle;
    logic busy;
    logic load;
    logic [DATA_W-1:0] ld_data;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_carry;
    logic              ld_ovf;

    assign free   = !bus.out_valid_o || bus.out_ready_i;
    assign drain  = bus.out_valid_o && bus.out_ready_i;
    assign accept = bus.in_valid_i && bus.in_ready_o;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

    state_e            state;
    state_e            state_nxt;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] acc;
    logic [TAG_W-1:0]  mul_tag;
    logic [CW-1:0]     count;
    logic              mul_start;
    logic              mul_done;
    logic              mul_load;

    assign mul_start = accept && (op == OP_MUL);
    assign mul_done  = (count == CW'(DATA_W));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        case (state)
            S_IDLE: if (mul_start) state_nxt = S_MUL;
            S_MUL: begin
                if (mul_done) begin
                    if (free) begin
                        mul_load  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (free) begin
                    mul_load  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One partial product per cycle; the cycle after the last add is spent loading.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_tag <= '0;
            acc     <= '0;
            count   <= '0;
        end else if (mul_start) begin
            mul_a   <= a;
            mul_b   <= b;
            mul_tag <= bus.tag_i;
            acc     <= '0;
            count   <= '0;
        end else if (state == S_MUL && !mul_done) begin
            if (mul_b[count[SW-1:0]]) acc <= acc + (mul_a << count[SW-1:0]);
            count <= count + 1'b1;
        end
    end

    assign idle     = (state == S_IDLE);
    assign busy     = !idle;
    assign load     = (accept && (op != OP_MUL)) || mul_load;
    assign ld_data  = mul_load ? acc     : res_c;
    assign ld_tag   = mul_load ? mul_tag : bus.tag_i;
    assign ld_carry = mul_load ? 1'b0    : carry_c;
    assign ld_ovf   = mul_load ? 1'b0    : ovf_c;
`else
    assign idle     = 1'b1;
    assign busy     = 1'b0;
    assign load     = accept;
    assign ld_data  = res_c;
    assign ld_tag   = bus.tag_i;
    assign ld_carry = carry_c;
    assign ld_ovf   = ovf_c;
`endif

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;
    logic              sign_q;
    logic              zero_q;
    logic              carry_q;
    logic              ovf_q;

    // A load in the same cycle as a drain keeps valid high with the new result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= ld_data;
            tag_q   <= ld_tag;
            sign_q  <= ld_data[DATA_W-1];
            zero_q  <= (ld_data == '0);
            carry_q <= ld_carry;
            ovf_q   <= ld_ovf;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready_o  = idle && free;
    assign bus.out_valid_o = valid_q;
    assign bus.alu_dt_o    = data_q;
    assign bus.tag_o       = tag_q;
    assign bus.sign_o      = sign_q;
    assign bus.zero_o      = zero_q;
    assign bus.carry_o     = carry_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.busy_o      = busy;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; result bundle compared as
// {valid, tag, data, sign, zero, carry, ovf}.
module tb_alu_seq;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ABS  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NEG  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MIN  = 4'b1100;
    localparam logic [3:0] OP_MAX  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_seq #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    logic [40:0] obs;
    assign obs = {bus.out_valid_o, bus.tag_o, bus.alu_dt_o,
                  bus.sign_o, bus.zero_o, bus.carry_o, bus.ovf_o};

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        bus.in_valid_i = 1'b1;
        bus.alu_op_i   = op;
        bus.dtA_i      = a;
        bus.dtB_i      = b;
        bus.tag_i      = t;
    endtask

    task automatic test_reset();
        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = '0;
        bus.dtA_i       = '0;
        bus.dtB_i       = '0;
        bus.tag_i       = '0;
        bus.out_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 41'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 41'h0);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
        end
    endtask

    task automatic test_add();
        logic [40:0] exp;
        bus.out_ready_i = 1'b1;
        drive(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3);
        @(negedge clk);
        exp = {1'b1, 4'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL add_carry: got %h expected %h", obs, exp);
        end
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd4);
        @(negedge clk);
        exp = {1'b1, 4'd4, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL add_ovf: got %h expected %h", obs, exp);
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL add_drain: got %b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[3] = '{OP_SUB, OP_SRA, OP_SLT};
        logic [31:0] as[3]  = '{32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0001};
        logic [40:0] exps[3] = '{
            {1'b1, 4'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0},
            {1'b1, 4'd2, 32'hF800_0000, 1'b1, 1'b0, 1'b0, 1'b0},
            {1'b1, 4'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0}};
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i], 4'(i + 1));
            @(negedge clk);
            n_checks++;
            if (obs !== exps[i]) begin
                n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, obs, exps[i]);
            end
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [3:0]  ops[14] = '{OP_ABS, OP_NEG, OP_ABS, OP_NEG, OP_SLL, OP_SRL, OP_SLTU,
                                 OP_SLT, OP_MIN, OP_MAX, OP_AND, OP_PASS, OP_SUB, OP_SUB};
        logic [31:0] as[14]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8000_0000, 32'h1,
                                 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                                 32'h1234_5678, 32'h8000_0000, 32'h0};
        logic [31:0] bs[14]  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'h5,
                                 32'h21, 32'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1,
                                 32'h0FF0_0FF0, 32'hDEAD_BEEF, 32'h1, 32'h0};
        logic [31:0] ed[14]  = '{32'h8000_0000, 32'h8000_0000, 32'h5, 32'hFFFF_FFFB, 32'h2,
                                 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h00F0_00F0,
                                 32'h1234_5678, 32'h7FFF_FFFF, 32'h0};
        // {sign, zero, carry, ovf}
        logic [3:0]  ef[14]  = '{4'b1001, 4'b1001, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0100};
        logic [40:0] exp;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(ops[i], as[i], bs[i], 4'(i));
            @(negedge clk);
            exp = {1'b1, 4'(i), ed[i], ef[i]};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL op_%0d: got %h expected %h", i, obs, exp);
            end
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [40:0] held;
        logic [40:0] exp;
        held = {1'b1, 4'd5, 32'hFF00_FF00, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_ready_i = 1'b0;
        drive(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5);
        @(negedge clk);
        drive(OP_OR, 32'h1, 32'h2, 4'd6);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs !== held) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %h expected %h", i, obs, held);
            end
            n_checks++;
            if (bus.in_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready_%0d: got %b expected 0", i, bus.in_ready_o);
            end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready_o);
        end
        @(negedge clk);
        exp = {1'b1, 4'd6, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL bp_next: got %h expected %h", obs, exp);
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_mul();
        logic [40:0] exp;
`ifdef ALU_MUL_EN
        int lat;
        logic bad;
        for (int pass = 0; pass < 2; pass++) begin
            bus.out_ready_i = 1'b1;
            drive(OP_MUL, 32'h0001_2345, 32'h0000_0100, 4'(7 + pass));
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            if (pass == 1) bus.out_ready_i = 1'b0;
            lat = 0;
            bad = 1'b0;
            for (int n = 1; n <= 40; n++) begin
                if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) bad = 1'b1;
                @(posedge clk);
                #1;
                if (bus.out_valid_o === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            n_checks++;
            if (lat != 33) begin
                n_fail++; $display("FAIL mul_latency_%0d: got %0d expected 33", pass, lat);
            end
            n_checks++;
            if (bad !== 1'b0) begin
                n_fail++; $display("FAIL mul_busy_%0d: got bad=%b expected 0", pass, bad);
            end
            exp = {1'b1, 4'(7 + pass), 32'h0123_4500, 1'b0, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp || bus.busy_o !== 1'b0) begin
                n_fail++; $display("FAIL mul_result_%0d: got %h busy %b expected %h busy 0",
                                   pass, obs, bus.busy_o, exp);
            end
            if (pass == 1) begin
                repeat (4) @(negedge clk);
                n_checks++;
                if (obs !== exp || bus.in_ready_o !== 1'b0) begin
                    n_fail++; $display("FAIL mul_hold: got %h ready %b expected %h ready 0",
                                       obs, bus.in_ready_o, exp);
                end
                bus.out_ready_i = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (bus.out_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL mul_drain_%0d: got %b expected 0", pass, bus.out_valid_o);
            end
        end
`else
        bus.out_ready_i = 1'b1;
        drive(OP_MUL, 32'h0001_2345, 32'h0000_0100, 4'd7);
        @(negedge clk);
        exp = {1'b1, 4'd7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp || bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL mul_disabled: got %h busy %b expected %h busy 0",
                               obs, bus.busy_o, exp);
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_op();
        logic stale;
`ifdef ALU_MUL_EN
        bus.out_ready_i = 1'b1;
        drive(OP_MUL, 32'h0001_2345, 32'h0000_0100, 4'd9);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus.busy_o);
        end
`else
        bus.out_ready_i = 1'b0;
        drive(OP_ADD, 32'h1, 32'h1, 4'd9);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        n_checks++;
        if (bus.out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_held: got %b expected 1", bus.out_valid_o);
        end
        bus.out_ready_i = 1'b1;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== 41'h0 || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_state: got %h busy %b ready %b expected 0 busy 0 ready 1",
                               obs, bus.busy_o, bus.in_ready_o);
        end
        stale = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stale: got %b expected 0", stale);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_ops();
        test_backpressure();
        test_mul();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
